// File: rtl/cdf_generator.sv
// cdf_generator: scans the histogram RAM once per frame and streams a saturated
// running CDF over valid/ready, plus the frame's first non-zero CDF value.
module cdf_generator #(
    parameter int NUM_BINS = 256,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 8,
    parameter int ACC_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              hist_rd_en,
    output logic [ADDR_W-1:0] hist_rd_addr,
    input  logic [CNT_W-1:0]  hist_rd_data,
    output logic [CNT_W-1:0]  cdf_out,
    output logic              cdf_valid,
    input  logic              cdf_ready,
    output logic [CNT_W-1:0]  cdf_min,
    output logic              cdf_min_valid,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, OUT, DONE} state_t;
    state_t state, state_next;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [ADDR_W-1:0] k;
    logic last;

    function automatic logic [CNT_W-1:0] sat(input logic [ACC_W-1:0] x);
        return |x[ACC_W-1:CNT_W] ? '1 : x[CNT_W-1:0];
    endfunction

    assign acc_sum      = acc + ACC_W'(hist_rd_data);
    assign last         = k == ADDR_W'(NUM_BINS - 1);
    assign hist_rd_addr = k;
    assign cdf_out      = sat(acc);
    assign busy         = state != IDLE;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;

    always_comb begin
        state_next = state;
        hist_rd_en = 1'b0;
        cdf_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: state_next = start ? RD : IDLE;
            RD: begin
                hist_rd_en = 1'b1;
                state_next = WAIT;
            end
            WAIT: state_next = OUT;
            OUT: begin
                cdf_valid  = 1'b1;
                state_next = !cdf_ready ? OUT : last ? DONE : RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc           <= '0;
            k             <= '0;
            cdf_min       <= '0;
            cdf_min_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            acc           <= '0;
            k             <= '0;
            cdf_min       <= '0;
            cdf_min_valid <= 1'b0;
        end else if (state == WAIT) begin
            acc <= acc_sum;
            if (!cdf_min_valid && |hist_rd_data) begin
                cdf_min       <= sat(acc_sum);
                cdf_min_valid <= 1'b1;
            end
        end else if (state == OUT && cdf_ready && !last) begin
            k <= k + 1'b1;
        end
endmodule

// File: doc/cdf_generator.md
# cdf_generator

Producer side of the equalization divider's `cdf_in` interface. The block scans the 256-bin intensity histogram memory once per frame and accumulates a running cumulative distribution, presenting one CDF value per bin through a valid/ready handshake. It also reports the frame's minimum non-zero CDF value. It sits between the histogram accumulator RAM and the divider stage.

## Interface
- `NUM_BINS`, 256, number of histogram bins scanned per frame (one per 8-bit intensity).
- `ADDR_W`, 8, histogram read address width; `NUM_BINS` equals 2^`ADDR_W`.
- `CNT_W`, 8, width of histogram bin counts and of `cdf_out`.
- `ACC_W`, 16, internal accumulator width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to scan a frame; sampled only in IDLE.
- `hist_rd_en`  out  1  histogram RAM read strobe.
- `hist_rd_addr`  out  ADDR_W  bin index being read.
- `hist_rd_data`  in  CNT_W  bin count; valid exactly one cycle after `hist_rd_en`.
- `cdf_out`  out  CNT_W  cumulative count through the current bin, saturated.
- `cdf_valid`  out  1  `cdf_out` is valid.
- `cdf_ready`  in  1  downstream accepts `cdf_out` this cycle.
- `cdf_min`  out  CNT_W  first non-zero CDF value of the frame.
- `cdf_min_valid`  out  1  `cdf_min` has been captured this frame.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last bin is accepted.

## Operation
- FSM states are IDLE, RD, WAIT, OUT and DONE.
- **IDLE:**
  - If `start` is high, clear the accumulator, the bin index `k`, `cdf_min` and `cdf_min_valid`, then go to RD.
  - `start` in any other state is ignored.
- **RD:** drive `hist_rd_en`=1 and `hist_rd_addr`=`k`, then go to WAIT.
- **WAIT:**
  - Update the accumulator: acc <= acc + `hist_rd_data`, zero-extended to `ACC_W`.
  - If `cdf_min_valid`=0 and `hist_rd_data`≠0, capture `cdf_min` <= sat(acc + `hist_rd_data`) and set `cdf_min_valid`.
  - Go to OUT.
- **OUT:**
  - `cdf_valid`=1 and `cdf_out`=sat(acc).
  - On `cdf_ready`=1: if `k`=`NUM_BINS`-1, go to DONE; otherwise `k` <= `k`+1 and go to RD.
  - While `cdf_ready`=0, stay in OUT. `cdf_out` is held stable throughout.
- **DONE:** `done`=1 for one cycle, then go to IDLE. `cdf_min`/`cdf_min_valid` hold until the next `start`.
- **Saturation:** sat(x) = 255 when x > 255, otherwise x[7:0]. The accumulator itself never wraps within a frame; the maximum is 256×255 < 2^16.
- **All-zero histogram:** `cdf_min_valid` stays 0 and `cdf_min` stays 0.
- **Combinational defaults:** `hist_rd_en`, `cdf_valid` and `done` are 0 outside the states named above.

## Timing
- **Reset values (asynchronous):**
  - State is IDLE.
  - `hist_rd_en`=0, `hist_rd_addr`=0.
  - `cdf_out`=0, `cdf_valid`=0.
  - `cdf_min`=0, `cdf_min_valid`=0.
  - `busy`=0, `done`=0.
  - Accumulator=0, `k`=0.
- **Reset mid-scan:** the scan is abandoned immediately. After deassertion, nothing restarts until a new `start`.
- **Start to first read:** `start` sampled at edge N puts RD in cycle N+1, with `hist_rd_en`=1 and address 0.
- **First output:** `hist_rd_data` is sampled in cycle N+2 (WAIT), and `cdf_valid` rises in cycle N+3.
- **Throughput:** 3 cycles per bin with `cdf_ready` held high. A full frame is 768 cycles.
- **Done:** `done` asserts the cycle after the final handshake. `busy` drops the cycle after that.
- **Backpressure:** each cycle of `cdf_ready`=0 in OUT adds one cycle.
- **`cdf_ready` outside OUT:** no effect.
- **Handshake rule:** exactly one transfer per bin (`cdf_valid`&&`cdf_ready`), and exactly `NUM_BINS` transfers per frame.

## Test plan
- **Uniform frame:**
  - Stimulus: bins 0..63 each=1, others 0, `cdf_ready`=1.
  - Required: `cdf_out` sequence 1,2,…,64, then 64 repeated for bins 64..255.
  - Required: `cdf_min`=1 with `cdf_min_valid`=1 after bin 0, `done` at cycle start+769, 256 transfers.
- **Single bin:**
  - Stimulus: bin 100=64, all others 0.
  - Required: `cdf_out`=0 for bins 0..99, then 64 for bins 100..255.
  - Required: `cdf_min`=64, captured in bin 100's WAIT.
- **All-zero histogram:**
  - Required: all 256 outputs = 0, `cdf_min_valid`=0 at `done`.
- **Saturation:**
  - Stimulus: bins 0..3 = 200.
  - Required: `cdf_out` 200 then 255,255,… for the rest of the frame; `cdf_min`=200.
- **Backpressure and ignored start:**
  - Stimulus: hold `cdf_ready`=0 for 5 cycles at bin 10, and pulse `start` while `busy`.
  - Required: `cdf_out` stable during the stall, frame length extended by 5 cycles, no restart, data unchanged.
- **Reset mid-scan:**
  - Stimulus: assert `reset`=0 during bin 50's OUT state.
  - Required: all outputs return to reset values asynchronously.
  - Required: after a new `start`, the scan restarts at address 0 with the accumulator cleared.
